// File: rtl/mmm_pkg.sv
// Shared types for the fetch front end: XLEN, BPU prediction, execute resolution
// and the fetch PC generator state encoding.
package mmm_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } prediction_t;

    typedef struct packed {
        logic            valid;
        logic            mispredict;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    // Instruction fetch is word aligned; loaded addresses drop their low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running handshake and redirect counters for the fetch PC generator.
// Instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_i,
    input  logic        redirect_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_o    <= '0;
            redirect_cnt_o <= '0;
        end else begin
            if (fetch_i)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (redirect_i)
                redirect_cnt_o <= redirect_cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/RUN/REDIR FSM steering pc_o from BPU predictions and
// execute redirects. Define FETCH_PERF_CNT_EN to add handshake/redirect counters.
module fetch_pc_gen
    import mmm_pkg::*;
#(
    parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  prediction_t     pred_i,
    input  resolution_t     res_i,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_valid_o,
    output prediction_t     fetch_pred_o,
    output logic            flush_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     redirect_cnt_o,
`endif
    output fetch_state_t    state_o
);

    // Handshake: a fetch is accepted when fetch_valid_o and fetch_ready_i are both
    // high at a rising edge. While stalled, pc_o and fetch_pred_o stay stable.
    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    prediction_t     pred_q;
    logic            hold_q;
    logic            redirect;
    logic            handshake;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] seq_pc;

    assign redirect    = res_i.valid & res_i.mispredict;
    assign handshake   = valid_q & fetch_ready_i;
    assign redirect_pc = align_pc(res_i.taken ? res_i.target : res_i.pc + XLEN'(4));

    // The first stalled cycle captures the prediction so later BPU updates
    // cannot change what is presented for the held PC.
    assign fetch_pred_o = !valid_q ? '0 : (hold_q ? pred_q : pred_i);
    assign seq_pc       = fetch_pred_o.taken ? align_pc(fetch_pred_o.target) : pc_q + XLEN'(4);

    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign flush_o       = redirect;
    assign state_o       = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= BOOT;
            pc_q    <= BOOT_ADDR;
            valid_q <= 1'b0;
            pred_q  <= '0;
            hold_q  <= 1'b0;
        end else if (redirect) begin
            state   <= REDIR;
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                    hold_q  <= 1'b0;
                end
                RUN: begin
                    if (handshake) begin
                        pc_q   <= seq_pc;
                        hold_q <= 1'b0;
                    end else begin
                        pred_q <= fetch_pred_o;
                        hold_q <= 1'b1;
                    end
                end
                REDIR: begin
                    state   <= RUN;
                    valid_q <= 1'b1;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state   <= BOOT;
                    valid_q <= 1'b0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt u_perf_cnt (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_i        (handshake),
        .redirect_i     (redirect),
        .fetch_cnt_o    (fetch_cnt_o),
        .redirect_cnt_o (redirect_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a monitor pops expected {pc, pred target}
// pairs on every accepted, non-flushed fetch; stimulus adds cycle-exact checks.
module tb_fetch_pc_gen;
    import mmm_pkg::*;

    logic            clk;
    logic            rst;
    prediction_t     pred;
    resolution_t     res;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic            valid;
    prediction_t     fpred;
    logic            flush;
    fetch_state_t    state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     fetch_cnt;
    logic [31:0]     redirect_cnt;
`endif

    logic            glitch;
    logic [63:0]     exp_q[$];
    int              checks;
    int              failures;

    fetch_pc_gen #(.BOOT_ADDR(32'h0000_0100)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pred_i         (pred),
        .res_i          (res),
        .fetch_ready_i  (ready),
        .pc_o           (pc),
        .fetch_valid_o  (valid),
        .fetch_pred_o   (fpred),
        .flush_o        (flush),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o    (fetch_cnt),
        .redirect_cnt_o (redirect_cnt),
`endif
        .state_o        (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small BPU model: a few fixed predictions, plus a disturbance used while stalled.
    always_comb begin
        pred = '0;
        if (pc == 32'h10) begin
            pred.taken  = 1'b1;
            pred.target = 32'h40;
        end else if (pc == 32'h40) begin
            pred.taken  = 1'b1;
            pred.target = 32'h23;
        end else if (pc == 32'h20 && glitch) begin
            pred.taken  = 1'b1;
            pred.target = 32'h999;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic taken, input logic [31:0] rpc, input logic [31:0] tgt);
        res            = '0;
        res.valid      = 1'b1;
        res.mispredict = 1'b1;
        res.taken      = taken;
        res.pc         = rpc;
        res.target     = tgt;
    endtask

    task automatic push(input logic [31:0] epc, input logic [31:0] etgt);
        exp_q.push_back({epc, etgt});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && valid && ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch: got pc 0x%08h expected none", pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("fetch_pc", pc, e[63:32]);
                check("fetch_pred_target", fpred.target, e[31:0]);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ready    = 1'b1;
        res      = '0;
        glitch   = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_pc", pc, 32'h100);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pred", fpred.target, 32'd0);
        check("rst_state", 32'(state), 32'(BOOT));

        // boot sequence
        step();
        rst = 1'b0;
        push(32'h100, 32'h0);
        push(32'h104, 32'h0);
        @(negedge clk);
        check("boot_valid", 32'(valid), 32'd0);
        check("boot_pc", pc, 32'h100);
        check("boot_state", 32'(state), 32'(BOOT));
        step();
        @(negedge clk);
        check("run_valid", 32'(valid), 32'd1);
        check("run_pc", pc, 32'h100);
        step();
        @(negedge clk);
        check("seq_pc", pc, 32'h104);

        // redirect to 0x10, then predicted-taken chain
        step();
        redirect_to(1'b1, 32'h0, 32'h10);
        @(negedge clk);
        check("flush_taken", 32'(flush), 32'd1);
        step();
        res = '0;
        @(negedge clk);
        check("redir_valid", 32'(valid), 32'd0);
        check("redir_pc", pc, 32'h10);
        check("redir_state", 32'(state), 32'(REDIR));
        push(32'h10, 32'h40);
        push(32'h40, 32'h23);
        push(32'h20, 32'h0);
        step();
        @(negedge clk);
        check("pred_fwd_target", fpred.target, 32'h40);
        step();
        @(negedge clk);
        check("pred_taken_pc", pc, 32'h40);

        // 3-cycle stall at 0x20 with a BPU disturbance
        step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'h20);
            check("stall_pred_taken", 32'(fpred.taken), 32'd0);
            check("stall_pred_target", fpred.target, 32'd0);
            step();
            if (i < 2) glitch = 1'b1;
        end
        glitch = 1'b0;
        ready  = 1'b1;
        step();
        ready = 1'b0;
        @(negedge clk);
        check("after_stall_pc", pc, 32'h24);

        // not-taken redirect during a stall
        step();
        redirect_to(1'b0, 32'h10, 32'h999);
        @(negedge clk);
        check("flush_stall", 32'(flush), 32'd1);
        step();
        res   = '0;
        ready = 1'b1;
        @(negedge clk);
        check("bubble_valid", 32'(valid), 32'd0);
        check("bubble_pc", pc, 32'h14);
        push(32'h14, 32'h0);
        step();
        @(negedge clk);
        check("resume_valid", 32'(valid), 32'd1);
        check("resume_pc", pc, 32'h14);

        // back-to-back redirects
        step();
        redirect_to(1'b1, 32'h0, 32'h80);
        @(negedge clk);
        check("b2b_flush", 32'(flush), 32'd1);
        step();
        redirect_to(1'b1, 32'h0, 32'h200);
        @(negedge clk);
        check("b2b_first_pc", pc, 32'h80);
        step();
        res = '0;
        @(negedge clk);
        check("b2b_state", 32'(state), 32'(REDIR));
        check("b2b_valid", 32'(valid), 32'd0);
        check("b2b_pc", pc, 32'h200);
        push(32'h200, 32'h0);
        step();
        @(negedge clk);
        check("b2b_run_pc", pc, 32'h200);

        // wrap of pc+4
        step();
        redirect_to(1'b0, 32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        check("pre_wrap_pc", pc, 32'h204);
        step();
        res = '0;
        @(negedge clk);
        check("wrap_pc", pc, 32'h0);

        // unaligned target is forced to word alignment
        step();
        redirect_to(1'b1, 32'h0, 32'h43);
        @(negedge clk);
        check("wrap_run_pc", pc, 32'h0);
        step();
        res = '0;
        @(negedge clk);
        check("align_pc", pc, 32'h40);
        push(32'h40, 32'h23);
        push(32'h20, 32'h0);
        step();
        step();

        // reset overrides a simultaneous redirect and handshake
        step();
        rst = 1'b1;
        redirect_to(1'b1, 32'h0, 32'h300);
        @(negedge clk);
        check("rst_flush", 32'(flush), 32'd1);
        check("pre_rst_pc", pc, 32'h24);
        step();
        res = '0;
        @(negedge clk);
        check("midrst_pc", pc, 32'h100);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_state", 32'(state), 32'(BOOT));
        check("midrst_pred", fpred.target, 32'd0);

`ifdef FETCH_PERF_CNT_EN
        check("cnt_rst_fetch", fetch_cnt, 32'd0);
        check("cnt_rst_redirect", redirect_cnt, 32'd0);
        step();
        rst = 1'b0;
        push(32'h100, 32'h0);
        push(32'h104, 32'h0);
        push(32'h108, 32'h0);
        push(32'h10C, 32'h0);
        push(32'h110, 32'h0);
        for (int i = 0; i < 6; i++) step();
        ready = 1'b0;
        redirect_to(1'b1, 32'h0, 32'h500);
        step();
        redirect_to(1'b1, 32'h0, 32'h600);
        step();
        res = '0;
        @(negedge clk);
        check("cnt_fetch", fetch_cnt, 32'd5);
        check("cnt_redirect", redirect_cnt, 32'd2);
        step();
        rst   = 1'b1;
        ready = 1'b1;
        step();
        @(negedge clk);
        check("cnt_clr_fetch", fetch_cnt, 32'd0);
        check("cnt_clr_redirect", redirect_cnt, 32'd0);
        check("cnt_clr_state", 32'(state), 32'(BOOT));
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
